// File: rtl/gpio_irq.sv
// ============================================================================
// Module   : gpio_irq
// Brief    : Parametrised GPIO port with per-pin direction, atomic set/clear,
//            synchronised inputs and optional edge interrupts (GPIO_IRQ_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_irq #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             gpio_cs,
  input  logic             wr_n,
  input  logic [4:0]       reg_addr_i,
  input  logic [7:0]       data_i,
  output logic [7:0]       data_o,
  output logic             irq_o,
  inout  wire  [WIDTH-1:0] gpio
);

  localparam logic [2:0] c_GRP_DATA = 3'd0;
  localparam logic [2:0] c_GRP_DIR  = 3'd1;
  localparam logic [2:0] c_GRP_EN   = 3'd2;
  localparam logic [2:0] c_GRP_POL  = 3'd3;
  localparam logic [2:0] c_GRP_STAT = 3'd4;
  localparam logic [2:0] c_GRP_SET  = 3'd5;
  localparam logic [2:0] c_GRP_CLR  = 3'd6;
  localparam logic [2:0] c_GRP_OUT  = 3'd7;

  logic [2:0]       w_grp;
  logic [1:0]       w_bank;
  logic             w_wr;
  logic [WIDTH-1:0] w_lane;
  logic [WIDTH-1:0] w_wbit;
  logic [WIDTH-1:0] w_wval;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_en_rd;
  logic [WIDTH-1:0] w_pol_rd;
  logic [WIDTH-1:0] w_stat_rd;
  logic [WIDTH-1:0] w_rd_vec;
  logic [31:0]      w_rd32;

  logic [WIDTH-1:0]                  r_out;
  logic [WIDTH-1:0]                  r_dir;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

  assign w_grp  = reg_addr_i[4:2];
  assign w_bank = reg_addr_i[1:0];
  assign w_wr   = gpio_cs & ~wr_n;
  assign w_wval = w_wbit & w_lane;

  // Each pin maps to one byte lane; pins beyond WIDTH simply do not exist.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_lane[i] = (w_bank == 2'(i / 8));
    assign w_wbit[i] = data_i[i % 8];
    assign gpio[i]   = r_dir[i] ? r_out[i] : 1'bz;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], gpio};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out <= '0;
      r_dir <= '0;
    end else if (w_wr) begin
      case (w_grp)
        c_GRP_DATA: r_out <= (r_out & ~w_lane) | w_wval;
        c_GRP_DIR:  r_dir <= (r_dir & ~w_lane) | w_wval;
        c_GRP_SET:  r_out <= r_out | w_wval;
        c_GRP_CLR:  r_out <= r_out & ~w_wval;
        default:    ;
      endcase
    end
  end

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] r_en;
  logic [WIDTH-1:0] r_pol;
  logic [WIDTH-1:0] r_stat;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_w1c;

  assign w_edge = ((w_s & ~r_prev) & ~r_pol) | ((~w_s & r_prev) & r_pol);
  assign w_w1c  = (w_wr && (w_grp == c_GRP_STAT)) ? w_wval : '0;

  // A fresh edge takes priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_en   <= '0;
      r_pol  <= '0;
      r_stat <= '0;
      r_prev <= '0;
    end else begin
      r_prev <= w_s;
      r_stat <= (r_stat & ~w_w1c) | (w_edge & r_en);
      if (w_wr && (w_grp == c_GRP_EN)) begin
        r_en <= (r_en & ~w_lane) | w_wval;
      end
      if (w_wr && (w_grp == c_GRP_POL)) begin
        r_pol <= (r_pol & ~w_lane) | w_wval;
      end
    end
  end

  assign irq_o     = |(r_stat & r_en);
  assign w_en_rd   = r_en;
  assign w_pol_rd  = r_pol;
  assign w_stat_rd = r_stat;
`else
  assign irq_o     = 1'b0;
  assign w_en_rd   = '0;
  assign w_pol_rd  = '0;
  assign w_stat_rd = '0;
`endif

  always_comb begin
    w_rd_vec = '0;
    case (w_grp)
      c_GRP_DATA: w_rd_vec = w_s;
      c_GRP_DIR:  w_rd_vec = r_dir;
      c_GRP_EN:   w_rd_vec = w_en_rd;
      c_GRP_POL:  w_rd_vec = w_pol_rd;
      c_GRP_STAT: w_rd_vec = w_stat_rd;
      c_GRP_OUT:  w_rd_vec = r_out;
      default:    w_rd_vec = '0;
    endcase
  end

  assign w_rd32 = 32'(w_rd_vec);
  assign data_o = w_rd32[{w_bank, 3'b000} +: 8];

endmodule

`default_nettype wire

// File: doc/gpio_irq.md
# gpio_irq

Parametrised general-purpose I/O port with per-pin direction, atomic set/clear of output bits, synchronised inputs and edge-triggered interrupts. It sits on the CPU I/O bus beside the existing peripherals and decodes its own byte-wide register window under `gpio_cs`. It supersedes the fixed 13-pin GPIO core, adding interrupt generation and wider ports.

## Interface
- `WIDTH`, 16: number of pins, 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.
- `clk_i` in 1: system clock.
- `rst_i` in 1: asynchronous reset, active high.
- `gpio_cs` in 1: block select.
- `wr_n` in 1: write strobe, active low; a write occurs on every clock edge where `gpio_cs` is 1 and `wr_n` is 0.
- `reg_addr_i` in 5: register address `{group[2:0], bank[1:0]}`; bank b covers pins 8b..8b+7.
- `data_i` in 8: write data.
- `data_o` out 8: read data, combinational from `reg_addr_i`.
- `irq_o` out 1: interrupt request, active high, level.
- `gpio` inout WIDTH: pads.

## Operation
- Register groups:
  - 0 DATA: read returns synchronised pin state; write loads the output latch.
  - 1 DIR: 1 = output.
  - 2 IRQ_EN.
  - 3 IRQ_POL: 0 = rising, 1 = falling.
  - 4 IRQ_STAT: write-1-to-clear.
  - 5 OUT_SET: write 1 sets latch bits; reads 0.
  - 6 OUT_CLR: write 1 clears latch bits; reads 0.
  - 7 OUT: reads the output latch; writes ignored.
- Pins at or above `WIDTH`, and banks with no pins, read 0 and ignore writes.
- Pad drive: `gpio[i]` is the latch bit when DIR[i] is 1, otherwise Z. DATA reads the pad through the synchroniser in both directions.
- Edge detect:
  - `s` is the last synchroniser stage; `p` is `s` delayed one clock.
  - Rising edge = `s & ~p`; falling edge = `~s & p`; POL selects which one counts.
- An edge on pin i sets STAT[i] only when IRQ_EN[i] is 1.
- STAT is sticky until cleared. If a set and a W1C on the same bit land in the same cycle, set wins.
- Clearing IRQ_EN does not clear STAT. `irq_o = |(STAT & IRQ_EN)`.
- Reads have no side effects.
- Reset values: all registers 0, synchroniser and `p` 0, every pad Z, `irq_o` 0, `data_o` = decode of the cleared registers. A high pin at reset release produces a rising edge, but no STAT bit sets because IRQ_EN is 0.
- Reset asserted mid-operation clears everything immediately, including pending STAT and the output drive.

## Timing
- Register writes take effect at the sampling edge. Pad drive and read-back follow in the same cycle after that edge.
- A pin change before edge N appears at `s`, and in DATA reads, after edge N+SYNC_STAGES-1.
- The corresponding STAT bit and `irq_o` assert after edge N+SYNC_STAGES.
- A W1C write at edge M deasserts `irq_o` after edge M, unless a new edge sets the bit at M.
- Pulses shorter than one clock may be missed. Pulses of at least 2 clocks are always detected.

## Configuration
- `GPIO_IRQ_EN` defined: edge-detect logic and groups 2–4 are built as described.
- `GPIO_IRQ_EN` undefined:
  - No edge-detect logic is built.
  - Groups 2–4 read 0 and ignore writes.
  - `irq_o` is tied to 0.
  - DATA, DIR, SET/CLR and OUT are unchanged.

## Test plan
- Reset, `WIDTH`=16: all pads Z; DIR/OUT/STAT read 0x00; `irq_o`=0; addresses for bank 2/3 read 0x00.
- Write DIR bank0=0x0F, DATA bank0=0xA5: pads[3:0]=0x5 and pads[7:4]=Z; OUT_SET 0xF0 then OUT_CLR 0x05 gives OUT bank0 = 0xF0.
- IRQ_EN bank1=0x01, POL=0; drive pin 8 from 0 to 1 before edge N: STAT bank1=0x01 and `irq_o`=1 after edge N+2; write 0x01 to STAT bank1: `irq_o`=0 the next cycle.
- POL bit set, pin 8 rises then falls: only the fall sets STAT; a 1-clock glitch aligned to an edge is caught, a 2-clock pulse always is.
- Edge detected in the same cycle as a W1C of that bit: STAT stays 1. Clearing IRQ_EN with STAT pending: `irq_o`=0 and STAT still reads 1.
- Assert `rst_i` while pads are driven and STAT is pending: pads go Z and `irq_o` goes 0 without a clock; build without `GPIO_IRQ_EN`: groups 2–4 read 0 and `irq_o` stays 0.
